// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and result bundle between the command source/result consumer/ALU and the sequencer.
// The sequencer takes the slave view; the surrounding environment (producer, consumer, ALU) takes the master view.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_chain;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_muxA;
  logic [3:0]  alu_muxB;
  logic [3:0]  alu_op;
  logic        alu_reset;
  logic [31:0] alu_result;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic [3:0]  res_op;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, alu_result, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_muxA, alu_muxB, alu_op, alu_reset,
           res_valid, res_data, res_err, res_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, alu_result, res_ready,
    output cmd_ready, alu_a, alu_b, alu_muxA, alu_muxB, alu_op, alu_reset,
           res_valid, res_data, res_err, res_op
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, filters unexecutable ones, sequences the ALU and returns results in order.
// Legal command: 4 cycles pop-to-consume; rejected command: 2 cycles; cmd_ready is a registered !full.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_cmd_sequencer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        chain;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  cmd_t          fifo_mem [DEPTH];
  cmd_t          wr_entry;
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          cmd_ready_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic          err;
  logic [15:0]   eff_b;
  logic [15:0]   last_result;
  state_t        state;

  assign wr_entry      = {bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_chain};
  assign head          = fifo_mem[rd_ptr];
  assign empty         = (count == '0);
  assign push          = bus.cmd_valid && cmd_ready_q;
  assign pop           = (state == IDLE) && !empty;
  assign bus.cmd_ready = cmd_ready_q;

  // Only the low half of the previous result can feed back as operand B.
  assign eff_b = head.chain ? last_result : head.b;
  assign err   = (head.op > 4'd12)
              || ((head.op == 4'd1) && (eff_b > head.a))
              || ((head.op == 4'd3) && (eff_b == 16'd0));

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count       <= count_nxt;
      cmd_ready_q <= (count_nxt != FULL_CNT);
    end
  end

  // ALU operands are registered on the pop edge so they are stable for the whole ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_result   <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_muxA  <= 2'b01;
      bus.alu_muxB  <= 4'b0001;
      bus.alu_op    <= '0;
      bus.alu_reset <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_err   <= 1'b0;
      bus.res_op    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (err) begin
              bus.res_valid <= 1'b1;
              bus.res_err   <= 1'b1;
              bus.res_data  <= '0;
              bus.res_op    <= head.op;
              state         <= DONE;
            end else begin
              bus.alu_reset <= 1'b0;
              bus.alu_a     <= head.a;
              bus.alu_b     <= eff_b;
              bus.alu_op    <= head.op;
              bus.alu_muxA  <= 2'b10;
              bus.alu_muxB  <= 4'b0100;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.alu_muxA <= 2'b01;
          bus.alu_muxB <= 4'b0001;
          state        <= CAPTURE;
        end
        CAPTURE: begin
          bus.res_data  <= bus.alu_result;
          bus.res_err   <= 1'b0;
          bus.res_op    <= bus.alu_op;
          bus.res_valid <= 1'b1;
          last_result   <= bus.alu_result[15:0];
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.alu_reset <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end that sits directly upstream of the 16-bit ALU.
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU operand, mux-select, op and reset inputs with the two-cycle register/capture timing the ALU needs.
- Captures the 32-bit result and returns it, with an error flag, over a second valid/ready handshake.
- Filters commands the ALU cannot execute cleanly (reserved ops, divide by zero, negative subtract) so the ALU never produces X.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO not full; reset 0.
- cmd_op  input  4  ALU opcode, 0–12 legal.
- cmd_a  input  16  operand A.
- cmd_b  input  16  operand B; ignored when cmd_chain=1.
- cmd_chain  input  1  use last_result[15:0] as B.
- alu_a  output  16  to ALU A; reset 0.
- alu_b  output  16  to ALU B; reset 0.
- alu_muxA  output  2  to ALU muxAInput; reset 2'b01.
- alu_muxB  output  4  to ALU muxBInput; reset 4'b0001.
- alu_op  output  4  to ALU op; reset 0.
- alu_reset  output  1  to ALU reset; reset 1.
- alu_result  input  32  from ALU acc_val.
- res_valid  output  1  result present; reset 0.
- res_ready  input  1  consumer accepts result.
- res_data  output  32  result; reset 0.
- res_err  output  1  command rejected; reset 0.
- res_op  output  4  opcode of the returned result; reset 0.

## Operation
- **FIFO.** Push on cmd_valid&&cmd_ready. Stores {op, a, b, chain}, 37 bits.
  - cmd_ready = !full; no bypass.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are allowed.
- **Command register.** Holds the popped entry. Effective B = chain ? last_result[15:0] : b.
  - last_result resets to 0.
  - last_result updates only on non-error captures.
- **Error check at pop** (using effective B). err = (op>12) || (op==1 && B>A) || (op==3 && B==0).
- **States:**
  - IDLE: alu_reset=1, alu_muxA=01, alu_muxB=0001. If FIFO non-empty: pop; go to DONE with res_err=1, res_data=0 if err, else go to ISSUE.
  - ISSUE: alu_reset=0, alu_a=A, alu_b=effective B, alu_muxA=10, alu_muxB=0100, alu_op=op. The ALU loads its operand registers at the edge. Next state CAPTURE.
  - CAPTURE: alu_muxA=01, alu_muxB=0001 (hold); alu_op and alu_reset=0 held. At the edge: res_data←alu_result, res_err←0, last_result←alu_result, res_valid←1. Next state DONE.
  - DONE: res_valid=1. On res_valid&&res_ready: res_valid←0, go to IDLE.
- **ALU-facing outputs** are driven from state and the command register. alu_a, alu_b and alu_op hold their last values outside ISSUE/CAPTURE.
- **res_* signals** are stable while res_valid=1 and res_ready=0.
- Results return in command order. Exactly one result per accepted command.
- **Reset** at any time, including mid-ISSUE, mid-CAPTURE or mid-DONE:
  - FIFO emptied, state IDLE, last_result=0.
  - All outputs take their reset values. The in-flight command is discarded.

## Timing
- Command handshake at edge k, FIFO initially empty, sequencer in IDLE:
  - pop at edge k+1;
  - ALU operand load at edge k+2;
  - res_valid high after edge k+3.
- Error command: res_valid high after edge k+1; ALU untouched (alu_reset stays 1).
- Throughput: one legal command per 4 cycles with res_ready tied high (IDLE, ISSUE, CAPTURE, DONE). An error command takes 2 cycles.
- Full-FIFO back-pressure: cmd_ready falls in the cycle after the push that makes count==DEPTH. It rises in the cycle after the next pop.
- The consumer stalling in DONE blocks further pops. The FIFO keeps accepting until full.

## Test plan
- Add op 0, A=5, B=6, res_ready=1 → res_data=11, res_err=0, res_valid 3 edges after the command handshake. alu_muxA=10 and alu_muxB=0100 during ISSUE.
- Sub op 1, A=3, B=5 → res_err=1, res_data=0 one edge after pop; alu_reset never deasserts. Then op 1, A=5, B=3 → res_data=2, res_err=0.
- Div op 3, A=9, B=0 → res_err=1. Op 14 → res_err=1. last_result unchanged (a following chain add with A=1 returns last legal result+1).
- Chain: mul op 2, A=7, B=6 → 42; then add, A=8, chain=1 → 50; then shift-left op 11, A=2, chain=1 → 200 (B<<A).
- Back-pressure, DEPTH=4: with res_ready=0, present 7 back-to-back commands → exactly 5 accepted (1 in the command register, 4 in the FIFO) and cmd_ready low. Raise res_ready → 5 results in order, no loss or duplication.
- Reset asserted asynchronously mid-CAPTURE, with 2 commands queued → cmd_ready=0, res_valid=0, alu_reset=1, alu_muxB=0001 immediately. After release: no results appear, and a new add 1+1 returns 2.
